// File: rtl/ws2812_strip_decoder.sv
// WS2812 receiver: classifies DI high pulses as bits, assembles 24-bit pixels and latches a strip image on each reset gap.
// Define WS2812_DECODER_PASSTHRU_EN to forward pixels beyond LENGTH on DO; otherwise DO is tied low.
module ws2812_strip_decoder #(
  parameter int LENGTH          = 10,
  parameter int BIT_THRESH_CLKS = 60,
  parameter int MIN_HIGH_CLKS   = 15,
  parameter int MAX_HIGH_CLKS   = 120,
  parameter int RESET_CLKS      = 5000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        DI,
  output logic [LENGTH*24-1:0]        strip,
  output logic [23:0]                 pixel,
  output logic                        pixel_valid,
  output logic [$clog2(LENGTH+1)-1:0] pixel_index,
  output logic                        frame_done,
  output logic                        frame_error,
  output logic                        DO
);

  localparam int IDX_W = $clog2(LENGTH + 1);
  localparam int HI_W  = $clog2(MAX_HIGH_CLKS + 2);
  localparam int LO_W  = $clog2(RESET_CLKS + 1);

  localparam logic [HI_W-1:0]  HI_MIN    = HI_W'(MIN_HIGH_CLKS);
  localparam logic [HI_W-1:0]  HI_MAX    = HI_W'(MAX_HIGH_CLKS);
  localparam logic [HI_W-1:0]  HI_THRESH = HI_W'(BIT_THRESH_CLKS);
  localparam logic [LO_W-1:0]  LO_MAX    = LO_W'(RESET_CLKS);
  localparam logic [LO_W-1:0]  LO_LAST   = LO_W'(RESET_CLKS - 1);
  localparam logic [IDX_W-1:0] PIX_MAX   = IDX_W'(LENGTH);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  state_t              state;
  logic                di_meta;
  logic                di_s;
  logic [HI_W-1:0]     hi_cnt;
  logic [LO_W-1:0]     lo_cnt;
  logic [4:0]          bit_cnt;
  logic [IDX_W-1:0]    pix_cnt;
  logic [23:0]         shift_reg;
  logic [23:0]         next_shift;
  logic [LENGTH*24-1:0] work_buf;
  logic                new_bit;
  logic                hi_bad;

  // hi_bad flags an over-long pulse while still high, or a glitch once the line has fallen.
  always_comb begin
    new_bit    = (hi_cnt >= HI_THRESH);
    next_shift = shift_reg;
    next_shift[5'd23 - bit_cnt] = new_bit;
    hi_bad     = di_s ? (hi_cnt >= HI_MAX) : (hi_cnt < HI_MIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      di_meta     <= 1'b0;
      di_s        <= 1'b0;
      state       <= WAIT_GAP;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shift_reg   <= '0;
      work_buf    <= '0;
      strip       <= '0;
      pixel       <= '0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      di_meta     <= DI;
      di_s        <= di_meta;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        WAIT_GAP: begin
          if (di_s) begin
            lo_cnt <= '0;
          end else if (lo_cnt == LO_LAST) begin
            lo_cnt <= LO_MAX;
            state  <= IDLE;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (di_s) begin
            hi_cnt <= HI_W'(1);
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (hi_bad) begin
            // The rest of this frame is untrustworthy, so drop it and resynchronise on a full gap.
            frame_error <= 1'b1;
            if (di_s) hi_cnt <= HI_MAX + 1'b1;
            lo_cnt  <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            state   <= WAIT_GAP;
          end else if (di_s) begin
            hi_cnt <= hi_cnt + 1'b1;
          end else begin
            lo_cnt <= LO_W'(1);
            state  <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt     <= '0;
              pixel       <= next_shift;
              pixel_valid <= 1'b1;
              pixel_index <= pix_cnt;
              if (pix_cnt != PIX_MAX) begin
                pix_cnt <= pix_cnt + 1'b1;
                for (int i = 0; i < LENGTH; i++) begin
                  if (pix_cnt == IDX_W'(i)) work_buf[(LENGTH-1-i)*24 +: 24] <= next_shift;
                end
              end
            end else begin
              shift_reg <= next_shift;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        LOW: begin
          if (di_s) begin
            hi_cnt <= HI_W'(1);
            state  <= HIGH;
          end else if (lo_cnt == LO_LAST) begin
            lo_cnt      <= LO_MAX;
            strip       <= work_buf;
            frame_done  <= 1'b1;
            frame_error <= (bit_cnt != 5'd0);
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            state       <= IDLE;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end
        default: state <= WAIT_GAP;
      endcase
    end
  end

`ifdef WS2812_DECODER_PASSTHRU_EN
  // Once LENGTH pixels are consumed, everything else on the line belongs to downstream LEDs.
  always_ff @(posedge clk) begin
    if (!rst_n) DO <= 1'b0;
    else        DO <= di_s && (pix_cnt == PIX_MAX);
  end
`else
  assign DO = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_strip_decoder.sv
// Randomised bench for ws2812_strip_decoder: a pulse-level model predicts pixels, frames and errors, checked every cycle.
module tb_ws2812_strip_decoder;

  localparam int LENGTH     = 10;
  localparam int BIT_THRESH = 60;
  localparam int MIN_HIGH   = 15;
  localparam int MAX_HIGH   = 120;
  localparam int RESET_CLKS = 5000;
  localparam int IDX_W      = $clog2(LENGTH + 1);
  localparam int GAP        = RESET_CLKS + 8;
  localparam int SW         = LENGTH * 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              di = 1'b0;
  logic [SW-1:0]     strip;
  logic [23:0]       pixel;
  logic              pixel_valid;
  logic [IDX_W-1:0]  pixel_index;
  logic              frame_done;
  logic              frame_error;
  logic              do_line;

  ws2812_strip_decoder #(
    .LENGTH(LENGTH), .BIT_THRESH_CLKS(BIT_THRESH), .MIN_HIGH_CLKS(MIN_HIGH),
    .MAX_HIGH_CLKS(MAX_HIGH), .RESET_CLKS(RESET_CLKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DI(di), .strip(strip), .pixel(pixel),
    .pixel_valid(pixel_valid), .pixel_index(pixel_index), .frame_done(frame_done),
    .frame_error(frame_error), .DO(do_line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; logic [23:0] val; int idx; } pix_ev_t;
  typedef struct { logic [SW-1:0] img; logic err; } frm_ev_t;

  pix_ev_t     pix_q[$];
  frm_ev_t     frm_q[$];
  int          err_q[$];
`ifdef WS2812_DECODER_PASSTHRU_EN
  bit          fwd[int];
`endif

  bit          m_synced = 1'b0;
  bit          m_got = 1'b0;
  int          m_bits = 0;
  int          m_pix = 0;
  logic [23:0] m_val = '0;
  logic [23:0] m_wb[LENGTH];

  logic             chk_en = 1'b0;
  logic             exp_pv = 1'b0;
  logic [23:0]      exp_pixel = '0;
  logic [IDX_W-1:0] exp_index = '0;
  logic [SW-1:0]    exp_strip = '0;
  logic             exp_err = 1'b0;
  logic             exp_do = 1'b0;
  int               pv_seen = 0;
  int               fd_seen = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check_output(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [SW-1:0] pack_wb();
    logic [SW-1:0] s;
    for (int i = 0; i < LENGTH; i++) s[(LENGTH-1-i)*24 +: 24] = m_wb[i];
    return s;
  endfunction

  // Per-cycle scoreboard: pixel events are cycle-exact (3 clk after the DI fall), frames are ordered.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_pv = 1'b0;
      if (pix_q.size() != 0 && pix_q[0].at == cyc) begin
        exp_pv    = 1'b1;
        exp_pixel = pix_q[0].val;
        exp_index = IDX_W'(pix_q[0].idx);
        void'(pix_q.pop_front());
      end
      while (err_q.size() != 0 && err_q[0] <= cyc) begin
        exp_err = 1'b1;
        void'(err_q.pop_front());
      end
      if (pixel_valid === 1'b1) pv_seen++;
      if (frame_done === 1'b1) begin
        fd_seen++;
        check_output("unexpected frame_done", SW'(frm_q.size() == 0), SW'(0));
        if (frm_q.size() != 0) begin
          exp_strip = frm_q[0].img;
          exp_err   = frm_q[0].err;
          void'(frm_q.pop_front());
        end
      end
`ifdef WS2812_DECODER_PASSTHRU_EN
      exp_do = fwd.exists(cyc - 3) ? 1'b1 : 1'b0;
`else
      exp_do = 1'b0;
`endif
      check_output("pixel_valid", SW'(pixel_valid), SW'(exp_pv));
      check_output("pixel", SW'(pixel), SW'(exp_pixel));
      check_output("pixel_index", SW'(pixel_index), SW'(exp_index));
      check_output("frame_error", SW'(frame_error), SW'(exp_err));
      check_output("strip", strip, exp_strip);
      check_output("DO", SW'(do_line), SW'(exp_do));
    end
  end

  task automatic drive(input logic level, input int n);
    di = level;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Pulse-level meaning of one high pulse that fell at cycle f.
  task automatic model_pulse(input int hw, input int f);
    if (!m_synced) return;
    if (hw < MIN_HIGH || hw > MAX_HIGH) begin
      err_q.push_back(f + 3);
      m_synced = 1'b0;
      m_bits   = 0;
      m_pix    = 0;
      m_got    = 1'b0;
      return;
    end
    m_got = 1'b1;
    m_val[23 - m_bits] = (hw >= BIT_THRESH);
    m_bits++;
    if (m_bits == 24) begin
      pix_q.push_back('{at: f + 3, val: m_val, idx: m_pix});
      if (m_pix < LENGTH) begin
        m_wb[m_pix] = m_val;
        m_pix++;
      end
      m_bits = 0;
    end
  endtask

  task automatic send_bit(input int hw, input int lw);
    int f;
`ifdef WS2812_DECODER_PASSTHRU_EN
    if (m_synced && m_pix >= LENGTH)
      for (int j = 0; j < hw; j++) fwd[cyc + j] = 1'b1;
`endif
    drive(1'b1, hw);
    f = cyc;
    model_pulse(hw, f);
    drive(1'b0, lw);
  endtask

  function automatic int zero_w();
    int r = $urandom_range(0, 7);
    if (r == 0) return MIN_HIGH;
    if (r == 1) return BIT_THRESH - 1;
    return $urandom_range(16, 22);
  endfunction

  function automatic int one_w();
    int r = $urandom_range(0, 7);
    if (r == 0) return BIT_THRESH;
    if (r == 1) return MAX_HIGH;
    return $urandom_range(61, 66);
  endfunction

  task automatic send_bits_fast(input logic [23:0] val, input int nbits);
    for (int b = 23; b > 23 - nbits; b--)
      send_bit(val[b] ? one_w() : zero_w(), $urandom_range(4, 10));
  endtask

  task automatic send_pixel_spec(input logic [23:0] val);
    for (int b = 23; b >= 0; b--) begin
      if (val[b]) send_bit(80, 42);
      else        send_bit(40, 82);
    end
  endtask

  task automatic send_gap();
    if (m_synced && m_got)
      frm_q.push_back('{img: pack_wb(), err: (m_bits != 0)});
    m_synced = 1'b1;
    m_got    = 1'b0;
    m_bits   = 0;
    m_pix    = 0;
    drive(1'b0, GAP);
    check_output("missing frame_done", SW'(frm_q.size()), SW'(0));
  endtask

  task automatic apply_reset_pulse();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix_q.delete();
    frm_q.delete();
    err_q.delete();
    for (int i = 0; i < LENGTH; i++) m_wb[i] = '0;
    m_synced  = 1'b0;
    m_got     = 1'b0;
    m_bits    = 0;
    m_pix     = 0;
    exp_pixel = '0;
    exp_index = '0;
    exp_strip = '0;
    exp_err   = 1'b0;
  endtask

  initial begin
    int pv0, fd0;
    logic [SW-1:0] t2_img, big_img, rst_img;
    logic [23:0] vals[12];

    for (int i = 0; i < LENGTH; i++) m_wb[i] = '0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n  = 1'b1;
    chk_en = 1'b1;
    send_gap();

    // Single spec-timed pixel.
    pv0 = pv_seen; fd0 = fd_seen;
    send_pixel_spec(24'hFF8001);
    send_gap();
    check_output("t1 pixel_valid count", SW'(pv_seen - pv0), SW'(1));
    check_output("t1 frame_done count", SW'(fd_seen - fd0), SW'(1));
    check_output("t1 pixel", SW'(pixel), SW'(24'hFF8001));
    check_output("t1 pixel_index", SW'(pixel_index), SW'(0));
    check_output("t1 strip pixel0", SW'(strip[SW-1 -: 24]), SW'(24'hFF8001));
    check_output("t1 frame_error", SW'(frame_error), SW'(0));

    // Full frame 1..10.
    pv0 = pv_seen; fd0 = fd_seen;
    for (int p = 0; p < LENGTH; p++) send_bits_fast(24'(p + 1), 24);
    send_gap();
    for (int i = 0; i < LENGTH; i++) t2_img[(LENGTH-1-i)*24 +: 24] = 24'(i + 1);
    check_output("t2 pixel_valid count", SW'(pv_seen - pv0), SW'(10));
    check_output("t2 strip pixel0", SW'(strip[SW-1 -: 24]), SW'(24'h000001));
    check_output("t2 strip pixel9", SW'(strip[23:0]), SW'(24'h00000A));
    check_output("t2 strip", strip, t2_img);

    // Glitch mid-pixel: error, no further pixels, no frame.
    pv0 = pv_seen; fd0 = fd_seen;
    send_bits_fast(24'($urandom), 24);
    send_bits_fast(24'($urandom), 24);
    send_bits_fast(24'($urandom), 5);
    send_bit(10, 30);
    check_output("t3 frame_error after glitch", SW'(frame_error), SW'(1));
    send_bits_fast(24'hFFFFFF, 24);
    send_gap();
    check_output("t3 pixel_valid count", SW'(pv_seen - pv0), SW'(2));
    check_output("t3 frame_done count", SW'(fd_seen - fd0), SW'(0));
    check_output("t3 strip unchanged", strip, t2_img);

    // 12 random pixels: first 10 stored, the rest dropped (or forwarded on DO).
    pv0 = pv_seen; fd0 = fd_seen;
    for (int p = 0; p < 12; p++) begin
      vals[p] = 24'($urandom);
      send_bits_fast(vals[p], 24);
    end
    send_gap();
    for (int i = 0; i < LENGTH; i++) big_img[(LENGTH-1-i)*24 +: 24] = vals[i];
    check_output("t4 pixel_valid count", SW'(pv_seen - pv0), SW'(12));
    check_output("t4 frame_done count", SW'(fd_seen - fd0), SW'(1));
    check_output("t4 frame_error cleared", SW'(frame_error), SW'(0));
    check_output("t4 strip", strip, big_img);
    check_output("t4 last pixel_index", SW'(pixel_index), SW'(LENGTH));

    // Partial pixel then gap.
    fd0 = fd_seen;
    send_bits_fast(24'($urandom), 12);
    send_gap();
    check_output("t5 frame_done count", SW'(fd_seen - fd0), SW'(1));
    check_output("t5 frame_error", SW'(frame_error), SW'(1));
    check_output("t5 strip keeps old pixels", strip, big_img);

    // Reset in the middle of pixel 3.
    for (int p = 0; p < 3; p++) send_bits_fast(24'($urandom), 24);
    send_bits_fast(24'($urandom), 10);
    apply_reset_pulse();
    check_output("rst strip", strip, SW'(0));
    check_output("rst pixel", SW'(pixel), SW'(0));
    check_output("rst frame_error", SW'(frame_error), SW'(0));
    send_bits_fast(24'($urandom), 8);
    send_gap();
    vals[0] = 24'($urandom);
    vals[1] = 24'($urandom);
    send_bits_fast(vals[0], 24);
    send_bits_fast(vals[1], 24);
    send_gap();
    rst_img = '0;
    rst_img[SW-1 -: 48] = {vals[0], vals[1]};
    check_output("rst new frame strip", strip, rst_img);
    check_output("rst new frame error", SW'(frame_error), SW'(0));

    repeat (4) begin @(posedge clk); #1; end
    check_output("pending pixel events", SW'(pix_q.size()), SW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
